scratchmem_burst: RTL and testbench
===================================

Name: scratchmem_burst

Overview:
Parametrised successor to the SoC scratchpad RAM. It provides byte-lane-writable on-chip memory on a Wishbone-style slave port, with configurable data width and depth. It adds true incrementing and wrapping burst reads with a stallable prefetch pipeline, plus an asynchronous active-low reset. It sits on the system bus beside the boot ROM as CPU scratch/stack memory.

Parameters:
DATA_WIDTH, 128, bus/word width in bits; power of two, 32..256
DEPTH, 4096, words of storage; power of two
ADDR_WIDTH, 16, width of adr_i; must be >= log2(DEPTH)+LSB, where LSB = log2(DATA_WIDTH/8)
SEL_WIDTH, DATA_WIDTH/8, byte-lane select width (derived)

Ports:
clk_i  in  1  clock; all state changes on rising edge
rst_ni  in  1  reset, asynchronous assert, active-low
cs_i  in  1  block select from address decoder
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe
we_i  in  1  write enable
cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end-of-burst
bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
sel_i  in  SEL_WIDTH  byte-lane enables
adr_i  in  ADDR_WIDTH  byte address; word index = adr_i[LSB+log2(DEPTH)-1:LSB]; upper bits ignored
dat_i  in  DATA_WIDTH  write data
bok_o  out  1  combinational: cs = cs_i&cyc_i&stb_i
ack_o  out  1  transfer acknowledge, registered
dat_o  out  DATA_WIDTH  read data, registered, valid when ack_o=1

Behaviour:
- Reset (rst_ni=0, async): ack_o=0, dat_o=0, pipeline valid bits=0, burst counter=0, state IDLE. Memory contents are not reset; they are zero-initialised for simulation.
- Reset mid-burst aborts the burst. No ack is issued until a new cs after rst_ni rises.
- Write: at edge k with cs&we_i, bytes with sel_i[n]=1 are written at the word index; other lanes are untouched. ack_o=1 in cycle k+1 only. Burst writes take the address from adr_i on every beat, at one ack per cycle.
- Classic read (cti=000): cs sampled at edge k. Array read at edge k+1. dat_o and ack_o=1 after edge k+2, for one cycle. The same request is never acked twice; a new request is accepted the cycle after ack.
- States: IDLE, RD_FILL, RD_STREAM, WR.
  - IDLE->WR on cs&we. WR stays while cs&we.
  - IDLE->RD_FILL on cs&!we. The counter loads word index, and the first prefetch is issued.
  - RD_FILL->RD_STREAM when the output stage becomes valid.
  - RD_STREAM->IDLE after the ack of a cti=111 or classic beat, or on cyc_i=0.
- Burst read (cti=010): first ack has latency 2 as for classic. After that, one ack per cycle while cs=1.
  - The prefetch counter advances each cycle the pipeline advances.
  - Linear: index+1, wrapping at DEPTH-1 -> 0.
  - wrapN: low log2(N) bits increment modulo N; upper bits are held.
- Stall: stb_i=0 with cyc_i=1 mid-burst freezes the counter and both pipeline stages, and ack_o=0. When stb_i returns, acks resume in the next cycle with the next sequential word; no beat is lost or duplicated.
- cyc_i=0 at any time: pipeline valid bits clear at the next edge, no stale ack follows, state goes to IDLE.
- Read after write to the same word returns the new data.
- A burst beat with cti=111 is the last beat. Prefetched words beyond it are discarded.
- cti/bte are sampled on the first beat of a burst; changes mid-burst (other than to 111) are ignored.

Test Plan:
1. Reset during RD_STREAM -> ack_o=0 and dat_o=0 immediately; after release, a classic read of word 5 acks exactly once, 2 cycles after cs.
2. Write word 3 with dat=0x00..0F..F and sel=0x00FF, then classic read word 3 -> low 8 bytes = 0xFF..FF, high 8 bytes unchanged (0).
3. Linear burst read of 6 beats from word 0x0FFE, with words preloaded to their index -> ack at cycles 2..7, data 0x0FFE, 0x0FFF, 0x000, 0x001, 0x002, 0x003.
4. wrap4 burst from word 0x012 -> data sequence 0x012, 0x013, 0x010, 0x011.
5. stb_i low for 3 cycles after the 2nd beat of an 8-beat linear burst -> no ack during the stall; beats 3..8 are contiguous, with no duplicates or gaps.
6. cyc_i dropped after the 2nd beat, then a classic read of another word -> exactly one ack, with that word's data.

Source files
------------

// File: rtl/scratchmem_burst_if.sv
// Wishbone-style slave bus of the burst scratchpad: request, burst control and response.
interface scratchmem_burst_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
);
    logic                  cs_i;
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [2:0]            cti_i;
    logic [1:0]            bte_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic                  bok_o;
    logic                  ack_o;
    logic [DATA_WIDTH-1:0] dat_o;

    modport master (
        output cs_i, cyc_i, stb_i, we_i, cti_i, bte_i, sel_i, adr_i, dat_i,
        input  bok_o, ack_o, dat_o
    );

    modport slave (
        input  cs_i, cyc_i, stb_i, we_i, cti_i, bte_i, sel_i, adr_i, dat_i,
        output bok_o, ack_o, dat_o
    );
endinterface

// File: rtl/scratchmem_burst.sv
// Byte-lane-writable scratchpad RAM with incrementing/wrapping burst reads through a
// two-stage stallable prefetch pipeline (counter -> array read -> registered output).
module scratchmem_burst #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = 16,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    scratchmem_burst_if.slave bus
);
    localparam int         LSB      = $clog2(SEL_WIDTH);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    typedef enum logic [1:0] {IDLE, RD_FILL, RD_STREAM, WR} state_t;

    state_t                state;
    logic [IDX_W-1:0]      cnt;
    logic                  burst_q;
    logic [1:0]            bte_q;
    logic                  s1_v;
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  fin;      // the last ack of the current transfer has been issued
    logic                  ack_q;
    logic [DATA_WIDTH-1:0] dat_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  go;
    logic                  wr_beat;
    logic                  rd_adv;
    logic                  rd_last;
    logic                  unused_adr;
    logic [IDX_W-1:0]      widx;
    logic [IDX_W-1:0]      cnt_inc;
    logic [IDX_W-1:0]      wrap_mask;
    logic [IDX_W-1:0]      cnt_next;

    assign go         = bus.cs_i & bus.cyc_i & bus.stb_i;
    assign widx       = bus.adr_i[LSB +: IDX_W];
    assign unused_adr = ^bus.adr_i;
    assign wr_beat    = go & bus.we_i & ((state == IDLE) | ((state == WR) & ~(ack_q & fin)));
    assign rd_adv     = go & ((state == RD_FILL) | ((state == RD_STREAM) & ~fin));
    assign rd_last    = ~burst_q | (bus.cti_i == CTI_END);

    assign bus.bok_o  = go;
    assign bus.ack_o  = ack_q;
    assign bus.dat_o  = dat_q;

    // Wrapping bursts step only the low log2(N) index bits; linear steps all of them.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        cnt_inc   = cnt + IDX_W'(1);
        wrap_mask = '1;
        case (bte_q)
            2'b01:   wrap_mask = IDX_W'(3);
            2'b10:   wrap_mask = IDX_W'(7);
            2'b11:   wrap_mask = IDX_W'(15);
            default: wrap_mask = '1;
        endcase
        cnt_next = (cnt & ~wrap_mask) | (cnt_inc & wrap_mask);
    end

    // NOTE: the array and its read register have no reset so they map onto block RAM.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < SEL_WIDTH; n++) begin
            if (wr_beat && bus.sel_i[n]) mem[widx][n*8 +: 8] <= bus.dat_i[n*8 +: 8];
        end
        if (rd_adv) s1_data <= mem[cnt];
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            burst_q <= 1'b0;
            bte_q   <= 2'b00;
            s1_v    <= 1'b0;
            fin     <= 1'b0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_q <= 1'b0;
            if (!bus.cyc_i) begin
                state <= IDLE;
                s1_v  <= 1'b0;
                fin   <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (go && bus.we_i) begin
                            ack_q <= 1'b1;
                            fin   <= (bus.cti_i != CTI_INCR);
                            state <= WR;
                        end else if (go) begin
                            cnt     <= widx;
                            burst_q <= (bus.cti_i == CTI_INCR);
                            bte_q   <= bus.bte_i;
                            fin     <= 1'b0;
                            state   <= RD_FILL;
                        end
                    end
                    WR: begin
                        if (wr_beat) begin
                            ack_q <= 1'b1;
                            fin   <= (bus.cti_i != CTI_INCR);
                        end else begin
                            fin   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    RD_FILL, RD_STREAM: begin
                        if (fin) begin
                            fin   <= 1'b0;
                            state <= IDLE;
                        end else if (rd_adv) begin
                            cnt  <= cnt_next;
                            s1_v <= 1'b1;
                            if (s1_v) begin
                                ack_q <= 1'b1;
                                dat_q <= s1_data;
                                state <= RD_STREAM;
                                // Words prefetched beyond the final beat are dropped.
                                if (rd_last) begin
                                    fin  <= 1'b1;
                                    s1_v <= 1'b0;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scratchmem_burst.sv
// Directed bench for scratchmem_burst: reset, byte lanes, linear/wrap bursts, stall and abort.
module tb_scratchmem_burst;
    localparam int DW    = 128;
    localparam int DEPTH = 4096;
    localparam int AW    = 16;
    localparam int SW    = DW / 8;
    localparam int LSB   = 4;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    scratchmem_burst_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    scratchmem_burst #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] got_dat [16];
    int            got_cyc [16];
    int            got_n;

    localparam logic [DW-1:0] PATTERN = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    function automatic logic [AW-1:0] adr_of(input int idx);
        return AW'(idx) << LSB;
    endfunction

    task automatic idle_bus();
        bus.cs_i = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.cti_i = 3'b000; bus.bte_i = 2'b00; bus.sel_i = '0; bus.adr_i = '0; bus.dat_i = '0;
    endtask

    // Single classic write beat, started and finished on a falling edge.
    task automatic write_word(input int idx, input logic [DW-1:0] data, input logic [SW-1:0] sel,
                              output logic acked);
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.cti_i = 3'b000; bus.bte_i = 2'b00; bus.adr_i = adr_of(idx); bus.dat_i = data; bus.sel_i = sel;
        @(negedge clk_i);
        acked = bus.ack_o;
        idle_bus();
        @(negedge clk_i);
    endtask

    // Read master: holds the request, optionally stalls or drops cyc, flags the last beat with 111,
    // then watches four idle cycles for stray acks. Cycle 0 is the cycle after the request edge.
    task automatic run_read(input int start, input logic [1:0] bte, input int nbeats,
                            input int stall_after, input int stall_len, input int drop_after);
        int cyc_idx;
        int stall_rem;
        int tail;
        bit active;
        got_n = 0; cyc_idx = -1; stall_rem = 0; tail = 0; active = 1'b1;
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.cti_i = (nbeats == 1) ? 3'b000 : 3'b010;
        bus.bte_i = bte; bus.adr_i = adr_of(start); bus.sel_i = '0; bus.dat_i = '0;
        while (tail < 4 && cyc_idx < 40) begin
            @(negedge clk_i);
            cyc_idx++;
            if (bus.ack_o) begin
                if (got_n < 16) begin
                    got_dat[got_n] = bus.dat_o;
                    got_cyc[got_n] = cyc_idx;
                end
                got_n++;
            end
            if (!active) begin
                tail++;
            end else if (got_n >= nbeats || (bus.ack_o && got_n == drop_after)) begin
                idle_bus();
                active = 1'b0;
            end else begin
                if (bus.ack_o && got_n == stall_after) stall_rem = stall_len;
                bus.stb_i = (stall_rem == 0);
                if (stall_rem > 0) stall_rem--;
                if (nbeats > 1 && got_n == nbeats - 1) bus.cti_i = 3'b111;
            end
        end
        if (active) idle_bus();
    endtask

    task automatic test_reset();
        idle_bus();
        #2;
        total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack: got %0b want 0", bus.ack_o); end
        total++; if (bus.dat_o !== '0) begin bad++; $display("FAIL reset_dat: got %0h want 0", bus.dat_o); end
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
        #1;
        total++; if (bus.bok_o !== 1'b1) begin bad++; $display("FAIL bok_on: got %0b want 1", bus.bok_o); end
        bus.stb_i = 1'b0;
        #1;
        total++; if (bus.bok_o !== 1'b0) begin bad++; $display("FAIL bok_stb_low: got %0b want 0", bus.bok_o); end
        idle_bus();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset_midburst();
        logic a;
        int late_acks;
        write_word(5, PATTERN, '1, a);
        bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.cti_i = 3'b010; bus.bte_i = 2'b00; bus.adr_i = adr_of(5);
        repeat (3) @(negedge clk_i);
        total++; if (bus.ack_o !== 1'b1 || bus.dat_o !== PATTERN) begin
            bad++; $display("FAIL midburst_first_beat: got ack=%0b dat=%0h want ack=1 dat=%0h", bus.ack_o, bus.dat_o, PATTERN);
        end
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        total++; if (bus.ack_o !== 1'b0) begin bad++; $display("FAIL async_reset_ack: got %0b want 0", bus.ack_o); end
        total++; if (bus.dat_o !== '0) begin bad++; $display("FAIL async_reset_dat: got %0h want 0", bus.dat_o); end
        idle_bus();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        late_acks = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (bus.ack_o) late_acks++;
        end
        total++; if (late_acks != 0) begin bad++; $display("FAIL post_reset_idle_acks: got %0d want 0", late_acks); end
        run_read(5, 2'b00, 1, -1, 0, -1);
        total++; if (got_n != 1) begin bad++; $display("FAIL classic_after_reset_count: got %0d want 1", got_n); end
        total++; if (got_n >= 1 && got_cyc[0] != 2) begin bad++; $display("FAIL classic_after_reset_latency: got %0d want 2", got_cyc[0]); end
        total++; if (got_n >= 1 && got_dat[0] !== PATTERN) begin bad++; $display("FAIL classic_after_reset_data: got %0h want %0h", got_dat[0], PATTERN); end
    endtask

    task automatic test_byte_write();
        logic a;
        logic [DW-1:0] exp;
        write_word(3, '0, '1, a);
        write_word(3, {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 16'h00FF, a);
        total++; if (a !== 1'b1) begin bad++; $display("FAIL write_ack: got %0b want 1", a); end
        run_read(3, 2'b00, 1, -1, 0, -1);
        exp = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
        total++; if (got_n != 1 || got_dat[0] !== exp) begin
            bad++; $display("FAIL lane_low8: got n=%0d dat=%0h want n=1 dat=%0h", got_n, got_dat[0], exp);
        end
        write_word(3, '1, 16'h0F00, a);
        run_read(3, 2'b00, 1, -1, 0, -1);
        exp = {32'h0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        total++; if (got_n != 1 || got_dat[0] !== exp) begin
            bad++; $display("FAIL lane_mid4: got n=%0d dat=%0h want n=1 dat=%0h", got_n, got_dat[0], exp);
        end
    endtask

    // Burst write of words 0x000..0x03F, 0xFFE, 0xFFF, each holding its own index.
    task automatic test_preload();
        int acks;
        int idx;
        acks = 0;
        for (int i = 0; i < 66; i++) begin
            idx = (i < 64) ? i : 'hFFE + (i - 64);
            bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
            bus.cti_i = (i == 65) ? 3'b111 : 3'b010; bus.sel_i = '1;
            bus.adr_i = adr_of(idx); bus.dat_i = DW'(idx);
            @(negedge clk_i);
            if (bus.ack_o) acks++;
        end
        idle_bus();
        @(negedge clk_i);
        total++; if (acks != 66) begin bad++; $display("FAIL preload_acks: got %0d want 66", acks); end
    endtask

    task automatic test_linear_burst();
        int exp [6] = '{'hFFE, 'hFFF, 'h000, 'h001, 'h002, 'h003};
        run_read('hFFE, 2'b00, 6, -1, 0, -1);
        total++; if (got_n != 6) begin bad++; $display("FAIL linear_count: got %0d want 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            total++; if (got_dat[i] !== DW'(exp[i]) || got_cyc[i] != i + 2) begin
                bad++; $display("FAIL linear_beat%0d: got dat=%0h cyc=%0d want dat=%0h cyc=%0d", i, got_dat[i], got_cyc[i], exp[i], i + 2);
            end
        end
    endtask

    task automatic test_wrap_burst();
        int exp4 [4] = '{'h12, 'h13, 'h10, 'h11};
        int exp8 [4] = '{'h1E, 'h1F, 'h18, 'h19};
        run_read('h12, 2'b01, 4, -1, 0, -1);
        total++; if (got_n != 4) begin bad++; $display("FAIL wrap4_count: got %0d want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            total++; if (got_dat[i] !== DW'(exp4[i])) begin
                bad++; $display("FAIL wrap4_beat%0d: got %0h want %0h", i, got_dat[i], exp4[i]);
            end
        end
        run_read('h1E, 2'b10, 4, -1, 0, -1);
        total++; if (got_n != 4) begin bad++; $display("FAIL wrap8_count: got %0d want 4", got_n); end
        for (int i = 0; i < 4; i++) begin
            total++; if (got_dat[i] !== DW'(exp8[i])) begin
                bad++; $display("FAIL wrap8_beat%0d: got %0h want %0h", i, got_dat[i], exp8[i]);
            end
        end
    endtask

    // Stall of three cycles after beat 2: beats 3..8 resume at cycle 7 with no gap or repeat.
    task automatic test_stall();
        int exp_cyc [8] = '{2, 3, 7, 8, 9, 10, 11, 12};
        run_read('h20, 2'b00, 8, 2, 3, -1);
        total++; if (got_n != 8) begin bad++; $display("FAIL stall_count: got %0d want 8", got_n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (got_dat[i] !== DW'('h20 + i) || got_cyc[i] != exp_cyc[i]) begin
                bad++; $display("FAIL stall_beat%0d: got dat=%0h cyc=%0d want dat=%0h cyc=%0d", i, got_dat[i], got_cyc[i], 'h20 + i, exp_cyc[i]);
            end
        end
    endtask

    task automatic test_cyc_drop();
        run_read('h30, 2'b00, 8, -1, 0, 2);
        total++; if (got_n != 2) begin bad++; $display("FAIL drop_acks: got %0d want 2", got_n); end
        total++; if (got_dat[0] !== DW'('h30) || got_dat[1] !== DW'('h31)) begin
            bad++; $display("FAIL drop_data: got %0h %0h want 30 31", got_dat[0], got_dat[1]);
        end
        run_read('h2A, 2'b00, 1, -1, 0, -1);
        total++; if (got_n != 1) begin bad++; $display("FAIL after_drop_count: got %0d want 1", got_n); end
        total++; if (got_dat[0] !== DW'('h2A) || got_cyc[0] != 2) begin
            bad++; $display("FAIL after_drop_read: got dat=%0h cyc=%0d want dat=2a cyc=2", got_dat[0], got_cyc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_midburst();
        test_byte_write();
        test_preload();
        test_linear_burst();
        test_wrap_burst();
        test_stall();
        test_cyc_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
